// File: rtl/sqrt_controller.sv
// Control FSM for the 16-bit integer square-root datapath.
// It runs init, then compare / root-increment / square-accumulate passes, with a watchdog limit.
module sqrt_controller #(
    parameter int MAX_ITER  = 256,
    parameter int CNT_WIDTH = 9
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic                 n_i,
    output logic                 boot_o,
    output logic                 wr_square_o,
    output logic                 wr_root_o,
    output logic                 muxes_o,
    output logic                 ready_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    output logic [CNT_WIDTH-1:0] iter_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_CHECK = 3'd2,
        S_INC   = 3'd3,
        S_ACC   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam logic [CNT_WIDTH-1:0] MaxIterC = CNT_WIDTH'(MAX_ITER);

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] iter_q, iter_d;
    logic                 err_q, err_d;

    logic boot_s, wr_square_s, wr_root_s;

    // State, iteration counter and sticky watchdog flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            iter_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            iter_q  <= iter_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic; n_i wins over the watchdog in CHECK
    always_comb begin
        state_d = state_q;
        iter_d  = iter_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_INIT;
                    iter_d  = '0;
                    err_d   = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_INIT:  state_d = S_CHECK;
            S_CHECK: begin
                if (n_i) begin
                    state_d = S_DONE;
                end else if (iter_q == MaxIterC) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                end else begin
                    state_d = S_INC;
                end
            end
            S_INC: begin
                state_d = S_ACC;
                iter_d  = iter_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end
            S_ACC:   state_d = S_CHECK;
            S_DONE:  state_d = S_IDLE;
            default: begin
                state_d = S_IDLE;
                iter_d  = '0;
                err_d   = 1'b0;
            end
        endcase
    end

    // Moore output decode from the state register
    always_comb begin
        boot_s      = 1'b0;
        wr_square_s = 1'b0;
        wr_root_s   = 1'b0;
        muxes_o     = 1'b0;
        ready_o     = 1'b0;
        busy_o      = 1'b0;
        done_o      = 1'b0;
        case (state_q)
            S_IDLE: ready_o = 1'b1;
            S_INIT: begin
                busy_o      = 1'b1;
                boot_s      = 1'b1;
                wr_square_s = 1'b1;
                wr_root_s   = 1'b1;
            end
            S_CHECK: begin
                busy_o  = 1'b1;
                muxes_o = 1'b1;
            end
            S_INC: begin
                busy_o    = 1'b1;
                wr_root_s = 1'b1;
            end
            S_ACC: begin
                busy_o      = 1'b1;
                wr_square_s = 1'b1;
            end
            S_DONE:  done_o = 1'b1;
            default: ready_o = 1'b0;
        endcase
    end

    // A reset arriving mid-run must not let the datapath registers load in that cycle
    assign boot_o      = boot_s      & ~rst;
    assign wr_square_o = wr_square_s & ~rst;
    assign wr_root_o   = wr_root_s   & ~rst;
    assign err_o       = err_q;
    assign iter_o      = iter_q;

endmodule
